// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program RAM, PC and IR, filled through a streaming load port.
// Optional build macro FETCH_BOUNDS_EN: HALT word on out-of-program fetch plus sticky FetchFault.
module instr_fetch_unit #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              PCClr,
    input  logic              PCUp,
    input  logic              IRLd,
    input  logic              LdStart,
    input  logic              LdValid,
    input  logic [15:0]       LdData,
    input  logic              LdLast,
    output logic              LdReady,
    output logic [15:0]       Instruction,
    output logic [ADDR_W-1:0] PCOut,
    output logic              Running,
    output logic              FetchFault
);

    typedef enum logic [1:0] {EMPTY, LOADING, LOADED} state_t;

`ifdef FETCH_BOUNDS_EN
    localparam logic [15:0] OOP_WORD = 16'h5000;
`else
    localparam logic [15:0] OOP_WORD = 16'h0000;
`endif

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, wptr;
    logic [ADDR_W:0]   ld_len;
    logic [15:0]       ir;
    logic [15:0]       ram [DEPTH];
    logic              accept, last_word, in_program;
    logic [15:0]       fetch_word;

    // LdStart wins over a same-cycle LdValid, so the word is dropped.
    assign accept     = (state == LOADING) && LdValid && !LdStart;
    assign last_word  = LdLast || (wptr == ADDR_W'(DEPTH - 1));
    assign in_program = {1'b0, pc} < ld_len;
    assign fetch_word = in_program ? ram[pc] : OOP_WORD;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= EMPTY;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (LdStart) state_next = LOADING;
            LOADING: if (accept && last_word) state_next = LOADED;
            LOADED:  if (LdStart) state_next = LOADING;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc     <= '0;
            ir     <= '0;
            wptr   <= '0;
            ld_len <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (LdStart) begin
                        wptr   <= '0;
                        ld_len <= '0;
                    end
                end
                LOADING: begin
                    if (LdStart) begin
                        wptr   <= '0;
                        ld_len <= '0;
                    end else if (LdValid) begin
                        wptr   <= wptr + 1'b1;
                        ld_len <= {1'b0, wptr} + 1'b1;
                        if (last_word) begin
                            pc <= '0;
                            ir <= '0;
                        end
                    end
                end
                LOADED: begin
                    if (LdStart) begin
                        wptr   <= '0;
                        ld_len <= '0;
                        pc     <= '0;
                        ir     <= '0;
                    end else begin
                        if (IRLd)       ir <= fetch_word;
                        if (PCClr)      pc <= '0;
                        else if (PCUp)  pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is deliberately not reset so a program survives Rst.
    always_ff @(posedge Clk) begin
        if (accept) ram[wptr] <= LdData;
    end

`ifdef FETCH_BOUNDS_EN
    logic fault;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fault <= 1'b0;
        end else if (state == LOADED) begin
            if (LdStart)                 fault <= 1'b0;
            else if (IRLd && !in_program) fault <= 1'b1;
        end
    end

    assign FetchFault = fault;
`else
    assign FetchFault = 1'b0;
`endif

    assign LdReady     = (state == LOADING);
    assign Running     = (state == LOADED);
    assign Instruction = ir;
    assign PCOut       = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: constant vector table, hand-written
// corner sequences and a randomized phase against a program-level reference model.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 2**ADDR_W;

`ifdef FETCH_BOUNDS_EN
    localparam logic        BND = 1'b1;
    localparam logic [15:0] OOP = 16'h5000;
`else
    localparam logic        BND = 1'b0;
    localparam logic [15:0] OOP = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pc_clr = 1'b0, pc_up = 1'b0, ir_ld = 1'b0;
    logic              ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [15:0]       ld_data = '0;
    logic              ld_ready, running, fetch_fault;
    logic [15:0]       instruction;
    logic [ADDR_W-1:0] pc_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: the loaded program as an array plus a length, PC and IR.
    logic [15:0] m_mem [DEPTH];
    bit          m_loading, m_running, m_fault;
    int          m_wptr, m_len, m_pc;
    logic [15:0] m_ir;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk(clk), .Rst(rst), .PCClr(pc_clr), .PCUp(pc_up), .IRLd(ir_ld),
        .LdStart(ld_start), .LdValid(ld_valid), .LdData(ld_data), .LdLast(ld_last),
        .LdReady(ld_ready), .Instruction(instruction), .PCOut(pc_out),
        .Running(running), .FetchFault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcclr, pcup, irld, ldstart, ldvalid, ldlast;
        logic [15:0] lddata;
        logic        exp_ready, exp_running, exp_fault;
        logic [6:0]  exp_pc;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mkVec(input logic c, u, i, s, v, l, input logic [15:0] d,
                                   input logic er, erun, input logic [6:0] epc,
                                   input logic [15:0] ein, input logic ef);
        vec_t t;
        t.pcclr = c; t.pcup = u; t.irld = i; t.ldstart = s; t.ldvalid = v; t.ldlast = l;
        t.lddata = d; t.exp_ready = er; t.exp_running = erun; t.exp_pc = epc;
        t.exp_instr = ein; t.exp_fault = ef;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_loading = 0; m_running = 0; m_fault = 0;
        m_wptr = 0; m_len = 0; m_pc = 0; m_ir = '0;
    endtask

    task automatic modelStep(input logic c, u, i, s, v, l, input logic [15:0] d);
        if (m_running) begin
            if (s) begin
                m_running = 0; m_loading = 1; m_wptr = 0; m_len = 0;
                m_pc = 0; m_ir = '0; m_fault = 0;
            end else begin
                if (i) begin
                    if (m_pc < m_len) m_ir = m_mem[m_pc];
                    else begin m_ir = OOP; m_fault = 1; end
                end
                if (c)      m_pc = 0;
                else if (u) m_pc = (m_pc + 1) % DEPTH;
            end
        end else if (m_loading) begin
            if (s) begin
                m_wptr = 0; m_len = 0;
            end else if (v) begin
                m_mem[m_wptr] = d;
                m_len = m_wptr + 1;
                if (l || m_len == DEPTH) begin
                    m_loading = 0; m_running = 1; m_pc = 0; m_ir = '0;
                end
                m_wptr = m_wptr + 1;
            end
        end else if (s) begin
            m_loading = 1; m_wptr = 0; m_len = 0;
        end
    endtask

    task automatic applyStimulus(input logic c, u, i, s, v, l, input logic [15:0] d);
        pc_clr = c; pc_up = u; ir_ld = i; ld_start = s; ld_valid = v; ld_last = l; ld_data = d;
        @(posedge clk);
        modelStep(c, u, i, s, v, l, d);
        #1;
        pc_clr = 0; pc_up = 0; ir_ld = 0; ld_start = 0; ld_valid = 0; ld_last = 0;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".ready"},   16'(ld_ready),    16'(m_loading));
        checkOutput({tag, ".running"}, 16'(running),     16'(m_running));
        checkOutput({tag, ".pc"},      16'(pc_out),      16'(m_pc));
        checkOutput({tag, ".instr"},   instruction,      m_ir);
        checkOutput({tag, ".fault"},   16'(fetch_fault), 16'(BND & m_fault));
    endtask

    logic [15:0] words [DEPTH];

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.ready",   16'(ld_ready),    16'h0);
        checkOutput("rst.running", 16'(running),     16'h0);
        checkOutput("rst.pc",      16'(pc_out),      16'h0);
        checkOutput("rst.instr",   instruction,      16'h0);
        checkOutput("rst.fault",   16'(fetch_fault), 16'h0);
        @(negedge clk);
        rst = 1'b1;

        // Test-plan program load and fetch sequence with constant expectations.
        vecs[0]  = mkVec(0,0,0,1,0,0,16'h0000, 1,0,7'd0,16'h0000,0);
        vecs[1]  = mkVec(0,0,0,0,1,0,16'h2034, 1,0,7'd0,16'h0000,0);
        vecs[2]  = mkVec(0,0,0,0,1,0,16'h3125, 1,0,7'd0,16'h0000,0);
        vecs[3]  = mkVec(0,0,0,0,1,1,16'h5000, 0,1,7'd0,16'h0000,0);
        vecs[4]  = mkVec(0,1,1,0,0,0,16'h0000, 0,1,7'd1,16'h2034,0);
        vecs[5]  = mkVec(0,1,1,0,0,0,16'h0000, 0,1,7'd2,16'h3125,0);
        vecs[6]  = mkVec(0,1,1,0,0,0,16'h0000, 0,1,7'd3,16'h5000,0);
        vecs[7]  = mkVec(0,0,1,0,0,0,16'h0000, 0,1,7'd3,OOP,BND);
        vecs[8]  = mkVec(1,0,0,0,0,0,16'h0000, 0,1,7'd0,OOP,BND);
        vecs[9]  = mkVec(0,1,0,0,0,0,16'h0000, 0,1,7'd1,OOP,BND);
        vecs[10] = mkVec(0,1,0,0,0,0,16'h0000, 0,1,7'd2,OOP,BND);
        vecs[11] = mkVec(1,1,0,0,0,0,16'h0000, 0,1,7'd0,OOP,BND);
        vecs[12] = mkVec(0,0,1,0,0,0,16'h0000, 0,1,7'd0,16'h2034,BND);
        vecs[13] = mkVec(0,0,0,0,1,0,16'hFFFF, 0,1,7'd0,16'h2034,BND);

        for (int k = 0; k < 14; k++) begin
            applyStimulus(vecs[k].pcclr, vecs[k].pcup, vecs[k].irld, vecs[k].ldstart,
                          vecs[k].ldvalid, vecs[k].ldlast, vecs[k].lddata);
            checkOutput($sformatf("vec%0d.ready", k),   16'(ld_ready),    16'(vecs[k].exp_ready));
            checkOutput($sformatf("vec%0d.running", k), 16'(running),     16'(vecs[k].exp_running));
            checkOutput($sformatf("vec%0d.pc", k),      16'(pc_out),      16'(vecs[k].exp_pc));
            checkOutput($sformatf("vec%0d.instr", k),   instruction,      vecs[k].exp_instr);
            checkOutput($sformatf("vec%0d.fault", k),   16'(fetch_fault), 16'(vecs[k].exp_fault));
        end

        // Full-depth load without LdLast, then a complete PC wrap.
        applyStimulus(0,0,0,1,0,0,16'h0);
        checkOutput("full.restart_fault", 16'(fetch_fault), 16'h0);
        for (int k = 0; k < DEPTH; k++) begin
            words[k] = 16'((k * 16'h0307) ^ 16'hA5C3);
            applyStimulus(0,0,0,0,1,0,words[k]);
            checkModel("full.load");
            if (k == DEPTH - 2) checkOutput("full.not_yet_running", 16'(running), 16'h0);
        end
        checkOutput("full.running", 16'(running),  16'h1);
        checkOutput("full.ready",   16'(ld_ready), 16'h0);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(0,1,1,0,0,0,16'h0);
            checkOutput("full.instr", instruction, words[k]);
            checkOutput("full.pc", 16'(pc_out), 16'((k + 1) % DEPTH));
        end
        applyStimulus(0,0,1,0,0,0,16'h0);
        checkOutput("full.wrap_instr", instruction, words[0]);
        checkOutput("full.wrap_fault", 16'(fetch_fault), 16'h0);

        // Asynchronous reset in the middle of a load.
        applyStimulus(0,0,0,1,0,0,16'h0);
        applyStimulus(0,0,0,0,1,0,16'h1234);
        applyStimulus(0,0,0,0,1,0,16'h5678);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("arst.ready",   16'(ld_ready),    16'h0);
        checkOutput("arst.running", 16'(running),     16'h0);
        checkOutput("arst.pc",      16'(pc_out),      16'h0);
        checkOutput("arst.instr",   instruction,      16'h0);
        checkOutput("arst.fault",   16'(fetch_fault), 16'h0);
        #1;
        rst = 1'b1;
        applyStimulus(0,1,1,0,0,0,16'h0);
        checkOutput("empty.pc",    16'(pc_out), 16'h0);
        checkOutput("empty.instr", instruction, 16'h0);
        applyStimulus(0,1,1,0,1,1,16'h9999);
        checkOutput("empty.running", 16'(running), 16'h0);
        checkOutput("empty.pc2",     16'(pc_out),  16'h0);

        // LdStart mid-load restarts at address 0.
        applyStimulus(0,0,0,1,0,0,16'h0);
        applyStimulus(0,0,0,0,1,0,16'hAAAA);
        applyStimulus(0,0,0,1,1,0,16'hBBBB);
        checkOutput("restart.ready", 16'(ld_ready), 16'h1);
        applyStimulus(0,0,0,0,1,1,16'h1111);
        checkOutput("restart.running", 16'(running), 16'h1);
        applyStimulus(0,0,1,0,0,0,16'h0);
        checkOutput("restart.instr", instruction, 16'h1111);
        applyStimulus(0,1,0,0,0,0,16'h0);
        applyStimulus(0,0,1,0,0,0,16'h0);
        checkOutput("restart.oop",   instruction,      OOP);
        checkOutput("restart.fault", 16'(fetch_fault), 16'(BND));
        checkModel("restart");

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            applyStimulus($urandom_range(7) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
                          $urandom_range(24) == 0, $urandom_range(3) != 0, $urandom_range(5) == 0,
                          16'($urandom));
            checkModel("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
